// File: rtl/trap_ctrl_pkg.sv
// Shared types, CSR addresses and field positions for the trap/mret sequencer.
package trap_ctrl_pkg;

  typedef logic [63:0] reg_t;
  typedef logic [11:0] csr_addr_t;

  typedef enum logic [2:0] {
    TrapIdle     = 3'd0,
    TrapWMepc    = 3'd1,
    TrapWMcause  = 3'd2,
    TrapWMtval   = 3'd3,
    TrapWMstatus = 3'd4,
    TrapMret     = 3'd5
  } trap_state_e;

  localparam csr_addr_t CsrMstatus = 12'h300;
  localparam csr_addr_t CsrMie     = 12'h304;
  localparam csr_addr_t CsrMepc    = 12'h341;
  localparam csr_addr_t CsrMcause  = 12'h342;
  localparam csr_addr_t CsrMtval   = 12'h343;

  localparam logic [4:0] CauseMTimerInt = 5'd7;

  localparam int MstatusIeBit  = 0;
  localparam int MstatusIe1Bit = 3;
  localparam int MieMtieBit    = 7;

  function automatic reg_t mstatus_val(input logic ie1, input logic ie);
    reg_t r;
    r = '0;
    r[MstatusIe1Bit] = ie1;
    r[MstatusIeBit]  = ie;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Owns the CSR write port: passes instruction writes through in IDLE and
// sequences the multi-cycle trap entry and mret writes, with shadowed ie/mtie/mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [63:0] MTVEC = 64'h0000_0000_8000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_cause_i,
  input  logic [63:0] exc_pc_i,
  input  logic [63:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        irq_timer_i,
  input  logic [63:0] irq_pc_i,
  input  logic        inst_we_i,
  input  csr_addr_t   inst_waddr_i,
  input  reg_t        inst_wdata_i,
  output logic        csr_we_o,
  output csr_addr_t   csr_waddr_o,
  output reg_t        csr_wdata_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o
);

  trap_state_e state_q;
  reg_t        pc_q, cause_q, tval_q, shadow_mepc_q;
  logic        shadow_ie_q, shadow_ie1_q, shadow_mtie_q;
  logic        irq_take;

  assign irq_take = shadow_ie_q & shadow_mtie_q & irq_timer_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TrapIdle;
      pc_q          <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      shadow_mepc_q <= '0;
      shadow_ie_q   <= 1'b0;
      shadow_ie1_q  <= 1'b0;
      shadow_mtie_q <= 1'b0;
    end else begin
      case (state_q)
        TrapIdle: begin
          if (exc_valid_i) begin
            pc_q    <= exc_pc_i;
            cause_q <= {59'h0, exc_cause_i};
            tval_q  <= exc_tval_i;
            state_q <= TrapWMepc;
          end else if (irq_take) begin
            pc_q    <= irq_pc_i;
            cause_q <= {1'b1, 58'h0, CauseMTimerInt};
            tval_q  <= '0;
            state_q <= TrapWMepc;
          end else if (mret_i) begin
            state_q <= TrapMret;
          end else if (inst_we_i) begin
            // Snoop pass-through writes so the CSR read port is never needed.
            if (inst_waddr_i == CsrMstatus) begin
              shadow_ie_q  <= inst_wdata_i[MstatusIeBit];
              shadow_ie1_q <= inst_wdata_i[MstatusIe1Bit];
            end
            if (inst_waddr_i == CsrMie)  shadow_mtie_q <= inst_wdata_i[MieMtieBit];
            if (inst_waddr_i == CsrMepc) shadow_mepc_q <= inst_wdata_i & ~64'h3;
          end
        end
        TrapWMepc: begin
          shadow_mepc_q <= pc_q & ~64'h3;
          state_q       <= TrapWMcause;
        end
        TrapWMcause: state_q <= TrapWMtval;
        TrapWMtval:  state_q <= TrapWMstatus;
        TrapWMstatus: begin
          shadow_ie1_q <= shadow_ie_q;
          shadow_ie_q  <= 1'b0;
          state_q      <= TrapIdle;
        end
        TrapMret: begin
          shadow_ie_q  <= shadow_ie1_q;
          shadow_ie1_q <= 1'b1;
          state_q      <= TrapIdle;
        end
        default: state_q <= TrapIdle;
      endcase
    end
  end

  always_comb begin
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      TrapIdle: begin
        // A same-cycle instruction write loses to any trap or mret and is dropped.
        if (!exc_valid_i && !irq_take && !mret_i) begin
          csr_we_o    = inst_we_i;
          csr_waddr_o = inst_waddr_i;
          csr_wdata_o = inst_wdata_i;
        end
      end
      TrapWMepc: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CsrMepc;
        csr_wdata_o = pc_q & ~64'h3;
      end
      TrapWMcause: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CsrMcause;
        csr_wdata_o = cause_q;
      end
      TrapWMtval: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CsrMtval;
        csr_wdata_o = tval_q;
      end
      TrapWMstatus: begin
        csr_we_o         = 1'b1;
        csr_waddr_o      = CsrMstatus;
        csr_wdata_o      = mstatus_val(shadow_ie_q, 1'b0);
        redirect_valid_o = 1'b1;
        redirect_pc_o    = MTVEC;
      end
      TrapMret: begin
        csr_we_o         = 1'b1;
        csr_waddr_o      = CsrMstatus;
        csr_wdata_o      = mstatus_val(1'b1, shadow_ie1_q);
        redirect_valid_o = 1'b1;
        redirect_pc_o    = shadow_mepc_q;
      end
      default: ;
    endcase
  end

  assign stall_o = (state_q != TrapIdle);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: drives and samples on the falling edge, checks
// every CSR write, stall and redirect against hand-computed values.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam logic [63:0] TB_MTVEC = 64'h0000_0000_8000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid_i;
  logic [4:0]  exc_cause_i;
  logic [63:0] exc_pc_i, exc_tval_i;
  logic        mret_i, irq_timer_i;
  logic [63:0] irq_pc_i;
  logic        inst_we_i;
  csr_addr_t   inst_waddr_i;
  reg_t        inst_wdata_i;
  logic        csr_we_o;
  csr_addr_t   csr_waddr_o;
  reg_t        csr_wdata_o;
  logic        stall_o, redirect_valid_o;
  logic [63:0] redirect_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.MTVEC(TB_MTVEC)) dut (
    .clk(clk), .rst(rst),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
    .mret_i(mret_i), .irq_timer_i(irq_timer_i), .irq_pc_i(irq_pc_i),
    .inst_we_i(inst_we_i), .inst_waddr_i(inst_waddr_i), .inst_wdata_i(inst_wdata_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then let combinational outputs settle.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_valid_i = 0; exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0;
    mret_i = 0; inst_we_i = 0; inst_waddr_i = '0; inst_wdata_i = '0;
  endtask

  task automatic chk_write(input string tag, input logic [11:0] a, input logic [63:0] d);
    chk({tag, "_we"}, {63'h0, csr_we_o}, 64'h1);
    chk({tag, "_addr"}, {52'h0, csr_waddr_o}, {52'h0, a});
    chk({tag, "_data"}, csr_wdata_o, d);
  endtask

  task automatic inst_write(input logic [11:0] a, input logic [63:0] d);
    inst_we_i = 1; inst_waddr_i = a; inst_wdata_i = d;
    #1;
    chk_write("passthru", a, d);
    chk("passthru_stall", {63'h0, stall_o}, 64'h0);
    cyc();
    idle_inputs();
  endtask

  initial begin
    rst = 1; irq_timer_i = 0; irq_pc_i = '0;
    idle_inputs();
    cyc();
    cyc();
    chk("rst_we", {63'h0, csr_we_o}, 64'h0);
    chk("rst_stall", {63'h0, stall_o}, 64'h0);
    chk("rst_redir", {63'h0, redirect_valid_o}, 64'h0);
    chk("rst_redir_pc", redirect_pc_o, 64'h0);
    rst = 0;
    cyc();

    inst_write(CsrMstatus, 64'h1);

    // Ecall with a simultaneous mret and mscratch write: only the trap proceeds.
    exc_valid_i = 1; exc_cause_i = 5'd11; exc_pc_i = 64'h8000_0100; exc_tval_i = '0;
    mret_i = 1; inst_we_i = 1; inst_waddr_i = 12'h340; inst_wdata_i = 64'hDEAD;
    #1;
    chk("accept_we_dropped", {63'h0, csr_we_o}, 64'h0);
    chk("accept_stall", {63'h0, stall_o}, 64'h0);
    cyc();
    idle_inputs();
    chk_write("t1_mepc", CsrMepc, 64'h8000_0100);
    chk("t1_stall", {63'h0, stall_o}, 64'h1);
    chk("t1_redir", {63'h0, redirect_valid_o}, 64'h0);
    cyc();
    chk_write("t2_mcause", CsrMcause, 64'hB);
    cyc();
    chk_write("t3_mtval", CsrMtval, 64'h0);
    cyc();
    chk_write("t4_mstatus", CsrMstatus, 64'h8);
    chk("t4_redir", {63'h0, redirect_valid_o}, 64'h1);
    chk("t4_redir_pc", redirect_pc_o, TB_MTVEC);
    chk("t4_stall", {63'h0, stall_o}, 64'h1);
    cyc();
    chk("t5_stall", {63'h0, stall_o}, 64'h0);
    chk("t5_redir", {63'h0, redirect_valid_o}, 64'h0);

    mret_i = 1;
    #1;
    chk("mret_accept_we", {63'h0, csr_we_o}, 64'h0);
    cyc();
    mret_i = 0;
    chk_write("mret_mstatus", CsrMstatus, 64'h9);
    chk("mret_redir", {63'h0, redirect_valid_o}, 64'h1);
    chk("mret_redir_pc", redirect_pc_o, 64'h8000_0100);
    chk("mret_stall", {63'h0, stall_o}, 64'h1);
    cyc();
    chk("mret_done_stall", {63'h0, stall_o}, 64'h0);

    // Masked interrupt: mtie set but ie cleared.
    inst_write(CsrMstatus, 64'h0);
    inst_write(CsrMie, 64'h80);
    irq_timer_i = 1; irq_pc_i = 64'h8000_0200;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("masked_we", {63'h0, csr_we_o}, 64'h0);
      chk("masked_stall", {63'h0, stall_o}, 64'h0);
      chk("masked_redir", {63'h0, redirect_valid_o}, 64'h0);
      cyc();
    end

    // Enabling ie makes the pending timer interrupt trap on the next cycle.
    inst_write(CsrMstatus, 64'h1);
    chk("irq_accept_we", {63'h0, csr_we_o}, 64'h0);
    cyc();
    irq_timer_i = 0;
    chk_write("irq_mepc", CsrMepc, 64'h8000_0200);
    cyc();
    chk_write("irq_mcause", CsrMcause, 64'h8000_0000_0000_0007);
    cyc();
    chk_write("irq_mtval", CsrMtval, 64'h0);
    cyc();
    chk_write("irq_mstatus", CsrMstatus, 64'h8);
    chk("irq_redir_pc", redirect_pc_o, TB_MTVEC);
    cyc();
    chk("irq_done_stall", {63'h0, stall_o}, 64'h0);

    // Software rewrites mepc with a misaligned value; mret uses the aligned copy.
    inst_write(CsrMepc, 64'h8000_0307);
    mret_i = 1;
    cyc();
    mret_i = 0;
    chk("mepc_mret_redir", {63'h0, redirect_valid_o}, 64'h1);
    chk("mepc_mret_pc", redirect_pc_o, 64'h8000_0304);
    chk_write("mepc_mret_mstatus", CsrMstatus, 64'h9);
    cyc();

    // Reset during the mcause write abandons the sequence.
    exc_valid_i = 1; exc_cause_i = 5'd2; exc_pc_i = 64'h8000_0400; exc_tval_i = 64'h55;
    cyc();
    idle_inputs();
    cyc();
    chk_write("rstmid_t2", CsrMcause, 64'h2);
    rst = 1;
    cyc();
    chk("rstmid_we", {63'h0, csr_we_o}, 64'h0);
    chk("rstmid_stall", {63'h0, stall_o}, 64'h0);
    chk("rstmid_redir", {63'h0, redirect_valid_o}, 64'h0);
    rst = 0;
    cyc();
    chk("rstmid_after_stall", {63'h0, stall_o}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Sequences trap entry and `mret` against the single-write-port machine CSR file. The block sits between the execute/commit stage and the CSR file and owns the CSR write port. It arbitrates instruction-issued CSR writes against its own multi-cycle trap write sequence, and it produces the pipeline stall and the PC redirect. It keeps shadow copies of `mstatus.ie`/`ie1`, `mie.mtie` and `mepc`, so it never needs the shared CSR read port.

## Interface
- `MTVEC`, default `64'h0000_0000_8000_0004`: trap vector PC. Must match the CSR file's hardwired `mtvec`.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `exc_valid_i` in 1: synchronous exception from the committing instruction.
- `exc_cause_i` in 5: exception code.
- `exc_pc_i` in 64: PC of the faulting instruction.
- `exc_tval_i` in 64: trap value.
- `mret_i` in 1: committing instruction is `mret`.
- `irq_timer_i` in 1: timer interrupt pending, level.
- `irq_pc_i` in 64: PC of the next instruction to execute; saved as `mepc` on an interrupt.
- `inst_we_i` in 1: instruction CSR write request.
- `inst_waddr_i` in `CSRAddrBus`: address of the instruction CSR write.
- `inst_wdata_i` in `RegBus`: data of the instruction CSR write.
- `csr_we_o` out 1: CSR file write enable.
- `csr_waddr_o` out `CSRAddrBus`: CSR file write address.
- `csr_wdata_o` out `RegBus`: CSR file write data.
- `stall_o` out 1: freeze fetch/commit.
- `redirect_valid_o` out 1: one-cycle PC redirect pulse.
- `redirect_pc_o` out 64: redirect target.

## Operation
- States: `IDLE`, `W_MEPC`, `W_MCAUSE`, `W_MTVAL`, `W_MSTATUS`, `W_MRET`.
- Priority in `IDLE`: exception > interrupt > `mret` > instruction write.
  - An interrupt is taken when `shadow_ie & shadow_mtie & irq_timer_i`.
- Accept cycle (in `IDLE`):
  - Latch pc, cause and tval. For an interrupt: pc = `irq_pc_i`, cause = `{1'b1, 58'h0, 5'd7}`, tval = 0. For an exception: `{1'b0, 58'h0, exc_cause_i}`.
  - Any same-cycle instruction write is dropped (not forwarded).
- Trap sequence, one CSR write per state:
  - `W_MEPC`: write `{pc[63:2], 2'b00}`; update `shadow_mepc`.
  - `W_MCAUSE`: write cause.
  - `W_MTVAL`: write tval.
  - `W_MSTATUS`: write `{60'h0, shadow_ie, 2'b0, 1'b0}`, i.e. ie1←ie, ie←0; update shadows. Pulse `redirect_valid_o` with `redirect_pc_o = MTVEC`. Next state `IDLE`.
- `mret` path, `W_MRET`: write mstatus with ie←ie1, ie1←1; update shadows. Pulse redirect to `shadow_mepc`. Next state `IDLE`.
- `IDLE` with no trap/`mret`: `inst_*` pass through combinationally to `csr_*`.
- Snooping: a passed-through write to `mstatus` updates `shadow_ie = wdata[0]` and `shadow_ie1 = wdata[3]`. Writes to `mie` update `shadow_mtie = wdata[7]`; writes to `mepc` update `shadow_mepc = {wdata[63:2], 2'b0}`.
- Outside `IDLE`, `inst_we_i` and all trap inputs are ignored; upstream is stalled.

## Timing
- Trap accepted at cycle T:
  - Writes at T+1 (mepc), T+2 (mcause), T+3 (mtval), T+4 (mstatus).
  - Redirect pulse at T+4.
  - `IDLE` again at T+5, when a new trap can be accepted.
- `mret` accepted at T: mstatus write and redirect at T+1, `IDLE` at T+2.
- `stall_o` = (state != `IDLE`), driven from the state register. No combinational path from trap inputs to `stall_o`.
- Instruction write pass-through has zero latency: the CSR file captures at the next edge.
- Interrupt level is sampled only in `IDLE`. If `irq_timer_i` is still high after return with ie=1, it re-traps at the first `IDLE` cycle.
- Reset values:
  - state `IDLE`.
  - shadows: ie=0, ie1=0, mtie=0, mepc=0. These match the CSR reset defines.
  - `csr_we_o` = 0, `stall_o` = 0, `redirect_valid_o` = 0, `redirect_pc_o` = 0.
- Reset mid-sequence: state returns to `IDLE` at the next edge and partial writes are not completed. The CSR file resets on the same `rst`, so state stays consistent.

## Structure
- `defines.v` additions:
  - state encodings (3-bit): `TrapIdle` … `TrapMret`.
  - `Cause_MTimerInt` = 5'd7.
  - `MstatusIeBit` = 0, `MstatusIe1Bit` = 3, `MieMtieBit` = 7.
- Reuses existing `CSR_Addr_*` defines and `Reg` for the state and shadow registers.
- Output select uses `MuxKeyWithDefault` keyed on state. No new sub-module.

## Test plan
- Ecall: `exc_valid_i`, cause 11, pc `0x80000100`, tval 0.
  - Writes mepc=`0x80000100`, mcause=`0xB`, mtval=0, mstatus=`0x8` (ie was 1) at T+1..T+4.
  - Redirect to `MTVEC` at T+4; `stall_o` high for T+1..T+4.
- Timer interrupt: ie=1 and mtie=1 (set via instruction writes), `irq_timer_i`=1, `irq_pc_i`=`0x80000200`.
  - mcause=`0x8000_0000_0000_0007`, mepc=`0x80000200`.
- Masked interrupt: ie=0, `irq_timer_i`=1 for 20 cycles → no write, no stall, no redirect.
- `mret` after trap: `redirect_pc_o`=`0x80000100` at T+1; mstatus written `0x9`.
- Simultaneous events:
  - exception + `mret` + instruction write to `mscratch` same cycle → trap sequence only; `mscratch` unchanged.
  - instruction write to `mepc` of `0x80000307`, then `mret` → redirect to `0x80000304`.
- Reset asserted at T+2 of a trap → T+3: state `IDLE`, `csr_we_o` = 0, `stall_o` = 0, no redirect pulse.
